// File: rtl/filter_tx_mem_responder.sv
// Two-channel operand-read responder: arbitrates ch0/ch1 onto a 1-cycle-latency L2 SRAM port,
// aligns/extends the read data and queues it per channel. Option: FILTER_TX_RESP_SIGNEXT_EN.
module filter_tx_mem_responder #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned L2_AWIDTH_NOAL = 15,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  input  logic                      ch0_req_i,
  input  logic [L2_AWIDTH_NOAL-1:0] ch0_addr_i,
  input  logic [1:0]                ch0_datasize_i,
  output logic                      ch0_gnt_o,
  output logic                      ch0_valid_o,
  output logic [DATA_WIDTH-1:0]     ch0_data_o,
  input  logic                      ch0_ready_i,
  input  logic                      ch1_req_i,
  input  logic [L2_AWIDTH_NOAL-1:0] ch1_addr_i,
  input  logic [1:0]                ch1_datasize_i,
  output logic                      ch1_gnt_o,
  output logic                      ch1_valid_o,
  output logic [DATA_WIDTH-1:0]     ch1_data_o,
  input  logic                      ch1_ready_i,
  output logic                      mem_req_o,
  output logic [L2_AWIDTH_NOAL-3:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [1:0]                         req, ready, elig, sel, gnt, push, pop, valid;
  logic [1:0][L2_AWIDTH_NOAL-1:0]     addr;
  logic [1:0][1:0]                    dsize;
  logic [1:0][DATA_WIDTH-1:0]         head;

  logic       last_q;  // 1: ch1 was granted last
  logic       pv_q, pch_q;
  logic [1:0] psize_q, poff_q;

  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic                  ext_byte, ext_half;
  logic [DATA_WIDTH-1:0] aligned;

  assign req   = {ch1_req_i, ch0_req_i};
  assign ready = {ch1_ready_i, ch0_ready_i};
  assign addr  = {ch1_addr_i, ch0_addr_i};
  assign dsize = {ch1_datasize_i, ch0_datasize_i};

  always_comb begin
    sel[0] = elig[0] & (~elig[1] | last_q);
    sel[1] = elig[1] & (~elig[0] | ~last_q);
  end

  // Grants are masked during reset so nothing is accepted while state is being cleared.
  assign gnt       = sel & {2{resetn_i}};
  assign ch0_gnt_o = gnt[0];
  assign ch1_gnt_o = gnt[1];
  assign mem_req_o = |gnt;

  always_comb begin
    mem_addr_o = '0;
    if (gnt[0]) begin
      mem_addr_o = addr[0][L2_AWIDTH_NOAL-1:2];
    end else if (gnt[1]) begin
      mem_addr_o = addr[1][L2_AWIDTH_NOAL-1:2];
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      last_q  <= 1'b1;
      pv_q    <= 1'b0;
      pch_q   <= 1'b0;
      psize_q <= '0;
      poff_q  <= '0;
    end else begin
      pv_q <= |gnt;
      if (|gnt) begin
        last_q  <= gnt[1];
        pch_q   <= gnt[1];
        psize_q <= gnt[1] ? dsize[1] : dsize[0];
        poff_q  <= gnt[1] ? addr[1][1:0] : addr[0][1:0];
      end
    end
  end

  assign sel_byte = mem_rdata_i[{poff_q, 3'b000} +: 8];
  assign sel_half = mem_rdata_i[{poff_q[1], 4'b0000} +: 16];

`ifdef FILTER_TX_RESP_SIGNEXT_EN
  assign ext_byte = sel_byte[7];
  assign ext_half = sel_half[15];
`else
  assign ext_byte = 1'b0;
  assign ext_half = 1'b0;
`endif

  always_comb begin
    case (psize_q)
      2'b00:   aligned = {{(DATA_WIDTH-8){ext_byte}}, sel_byte};
      2'b01:   aligned = {{(DATA_WIDTH-16){ext_half}}, sel_half};
      default: aligned = mem_rdata_i;
    endcase
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [CNT_W-1:0]      credit_q;
    logic [PTR_W:0]        wptr_q, rptr_q;
    logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];

    // Credit covers queued entries plus the read in flight, so a push can never overflow.
    assign elig[c]  = req[c] & (credit_q < CNT_W'(FIFO_DEPTH));
    assign valid[c] = (wptr_q != rptr_q);
    assign push[c]  = pv_q & (pch_q == 1'(c));
    assign pop[c]   = valid[c] & ready[c];
    assign head[c]  = valid[c] ? fifo_q[rptr_q[PTR_W-1:0]] : '0;

    always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
        credit_q <= '0;
        wptr_q   <= '0;
        rptr_q   <= '0;
      end else begin
        if (gnt[c] && !pop[c]) begin
          credit_q <= credit_q + 1'b1;
        end else if (!gnt[c] && pop[c]) begin
          credit_q <= credit_q - 1'b1;
        end
        if (push[c]) wptr_q <= wptr_q + 1'b1;
        if (pop[c])  rptr_q <= rptr_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (push[c]) fifo_q[wptr_q[PTR_W-1:0]] <= aligned;
    end
  end

  assign ch0_valid_o = valid[0];
  assign ch1_valid_o = valid[1];
  assign ch0_data_o  = head[0];
  assign ch1_data_o  = head[1];

endmodule
